// File: rtl/hci_core_req_fifo.sv
// Request FIFO between an HCI core requester and the wide port of a split stage.
// Buffers requests in order, caps in-flight reads and forwards responses upstream unchanged.
module hci_core_req_fifo #(
    parameter int unsigned DW              = 64,
    parameter int unsigned AW              = 32,
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned UW              = 1,
    parameter int unsigned BW              = 8
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       clear_i,
    // upstream requester
    input  logic                                       tcdm_slave_req_i,
    output logic                                       tcdm_slave_gnt_o,
    input  logic [AW-1:0]                              tcdm_slave_add_i,
    input  logic                                       tcdm_slave_wen_i,
    input  logic [DW/8-1:0]                            tcdm_slave_be_i,
    input  logic [DW-1:0]                              tcdm_slave_data_i,
    input  logic                                       tcdm_slave_lrdy_i,
    output logic [DW-1:0]                              tcdm_slave_r_data_o,
    output logic                                       tcdm_slave_r_valid_o,
    output logic                                       tcdm_slave_r_opc_o,
    output logic [UW-1:0]                              tcdm_slave_r_user_o,
    // downstream split stage
    output logic                                       tcdm_master_req_o,
    input  logic                                       tcdm_master_gnt_i,
    output logic [AW-1:0]                              tcdm_master_add_o,
    output logic                                       tcdm_master_wen_o,
    output logic [DW/8-1:0]                            tcdm_master_be_o,
    output logic [DW-1:0]                              tcdm_master_data_o,
    output logic [BW-1:0]                              tcdm_master_boffs_o,
    output logic [UW-1:0]                              tcdm_master_user_o,
    output logic                                       tcdm_master_lrdy_o,
    input  logic [DW-1:0]                              tcdm_master_r_data_i,
    input  logic                                       tcdm_master_r_valid_i,
    input  logic                                       tcdm_master_r_opc_i,
    // status
    output logic                                       empty_o,
    output logic                                       full_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]       outstanding_o,
    output logic                                       resp_err_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [AW-1:0]   add;
        logic            wen;
        logic [DW/8-1:0] be;
        logic [DW-1:0]   data;
    } entry_t;

    entry_t         r_mem [DEPTH];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic [OW-1:0]  r_out;
    logic           r_err;

    entry_t         w_head;
    entry_t         w_in;
    logic           w_flush;
    logic           w_full;
    logic           w_empty;
    logic           w_gnt;
    logic           w_req;
    logic           w_push;
    logic           w_pop;
    logic           w_rd_issue;
    logic           w_rsp;

    assign w_flush    = rst_i | clear_i;
    assign w_full     = (r_count == CW'(DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_head     = r_mem[r_rptr];
    assign w_in       = '{add: tcdm_slave_add_i, wen: tcdm_slave_wen_i,
                          be: tcdm_slave_be_i, data: tcdm_slave_data_i};

    // Reads wait at the head once the in-flight limit is reached; writes always go.
    assign w_gnt      = ~w_full & ~w_flush;
    assign w_req      = ~w_empty & ~w_flush & (~w_head.wen | (r_out < OW'(MAX_OUTSTANDING)));
    assign w_push     = tcdm_slave_req_i & w_gnt;
    assign w_pop      = w_req & tcdm_master_gnt_i;
    assign w_rd_issue = w_pop & w_head.wen;
    assign w_rsp      = tcdm_master_r_valid_i & (r_out != '0);

    assign tcdm_slave_gnt_o     = w_gnt;
    assign tcdm_master_req_o    = w_req;
    assign tcdm_master_add_o    = w_head.add;
    assign tcdm_master_wen_o    = w_head.wen;
    assign tcdm_master_be_o     = w_head.be;
    assign tcdm_master_data_o   = w_head.data;
    assign tcdm_master_boffs_o  = '0;
    assign tcdm_master_user_o   = '0;
    assign tcdm_master_lrdy_o   = tcdm_slave_lrdy_i;
    assign tcdm_slave_r_data_o  = tcdm_master_r_data_i;
    assign tcdm_slave_r_valid_o = tcdm_master_r_valid_i;
    assign tcdm_slave_r_opc_o   = tcdm_master_r_opc_i;
    assign tcdm_slave_r_user_o  = '0;

    assign empty_o       = w_empty;
    assign full_o        = w_full;
    assign outstanding_o = r_out;
    assign resp_err_o    = r_err;

    // Entry storage; contents need no reset since pointers gate their use.
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_in;
        end
    end

    // Pointers and occupancy; reset and clear both discard pending entries.
    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            if (w_push & ~w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_pop & ~w_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // In-flight read tracking; a response with nothing outstanding is flagged, never underflows.
    always_ff @(posedge clk_i) begin
        if (w_flush) begin
            r_out <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_rd_issue & ~w_rsp) begin
                r_out <= r_out + OW'(1);
            end else if (w_rsp & ~w_rd_issue) begin
                r_out <= r_out - OW'(1);
            end
            if (tcdm_master_r_valid_i & (r_out == '0)) begin
                r_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hci_core_req_fifo.sv
// Randomized bench for hci_core_req_fifo against a queue-based reference model.
module tb_hci_core_req_fifo;

    localparam int unsigned DW    = 64;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned MAXO  = 2;
    localparam int unsigned UW    = 1;
    localparam int unsigned BW    = 8;

    typedef struct {
        logic [AW-1:0]   add;
        logic            wen;
        logic [DW/8-1:0] be;
        logic [DW-1:0]   data;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, clr;
    logic            s_req, s_gnt, s_wen, s_lrdy;
    logic [AW-1:0]   s_add;
    logic [DW/8-1:0] s_be;
    logic [DW-1:0]   s_data, s_rdata;
    logic            s_rvalid, s_ropc;
    logic [UW-1:0]   s_ruser;
    logic            m_req, m_gnt, m_wen, m_lrdy;
    logic [AW-1:0]   m_add;
    logic [DW/8-1:0] m_be;
    logic [DW-1:0]   m_data, m_rdata;
    logic [BW-1:0]   m_boffs;
    logic [UW-1:0]   m_user;
    logic            m_rvalid, m_ropc;
    logic            empty, full, rerr;
    logic [1:0]      outst;

    hci_core_req_fifo #(
        .DW(DW), .AW(AW), .DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO), .UW(UW), .BW(BW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .clear_i(clr),
        .tcdm_slave_req_i(s_req), .tcdm_slave_gnt_o(s_gnt), .tcdm_slave_add_i(s_add),
        .tcdm_slave_wen_i(s_wen), .tcdm_slave_be_i(s_be), .tcdm_slave_data_i(s_data),
        .tcdm_slave_lrdy_i(s_lrdy), .tcdm_slave_r_data_o(s_rdata),
        .tcdm_slave_r_valid_o(s_rvalid), .tcdm_slave_r_opc_o(s_ropc),
        .tcdm_slave_r_user_o(s_ruser),
        .tcdm_master_req_o(m_req), .tcdm_master_gnt_i(m_gnt), .tcdm_master_add_o(m_add),
        .tcdm_master_wen_o(m_wen), .tcdm_master_be_o(m_be), .tcdm_master_data_o(m_data),
        .tcdm_master_boffs_o(m_boffs), .tcdm_master_user_o(m_user),
        .tcdm_master_lrdy_o(m_lrdy), .tcdm_master_r_data_i(m_rdata),
        .tcdm_master_r_valid_i(m_rvalid), .tcdm_master_r_opc_i(m_ropc),
        .empty_o(empty), .full_o(full), .outstanding_o(outst), .resp_err_o(rerr)
    );

    int   n_chk  = 0;
    int   n_pass = 0;
    ent_t mq[$];
    int   m_out  = 0;
    bit   m_err  = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Compare DUT to the model mid-cycle, then advance the model by one clock.
    task automatic step();
        bit   e_gnt, e_req, pop, push, inc, dec;
        ent_t e;
        @(negedge clk);
        e_gnt = (mq.size() < DEPTH) && !rst && !clr;
        e_req = !rst && !clr && (mq.size() > 0) && (mq[0].wen == 1'b0 || m_out < MAXO);
        check("empty",  64'(empty), 64'(mq.size() == 0));
        check("full",   64'(full),  64'(mq.size() == DEPTH));
        check("outst",  64'(outst), 64'(m_out));
        check("rerr",   64'(rerr),  64'(m_err));
        check("s_gnt",  64'(s_gnt), 64'(e_gnt));
        check("m_req",  64'(m_req), 64'(e_req));
        if (mq.size() > 0 && !rst && !clr) begin
            check("m_add",  64'(m_add),  64'(mq[0].add));
            check("m_wen",  64'(m_wen),  64'(mq[0].wen));
            check("m_be",   64'(m_be),   64'(mq[0].be));
            check("m_data", m_data, mq[0].data);
        end
        check("r_valid", 64'(s_rvalid), 64'(m_rvalid));
        check("r_data",  s_rdata, m_rdata);
        check("r_opc",   64'(s_ropc), 64'(m_ropc));
        check("lrdy",    64'(m_lrdy), 64'(s_lrdy));
        check("zeros",   64'({s_ruser, m_user, m_boffs}), 64'(0));
        if (rst || clr) begin
            mq.delete();
            m_out = 0;
            m_err = 1'b0;
        end else begin
            pop  = e_req && m_gnt;
            push = s_req && e_gnt;
            inc  = pop && mq[0].wen;
            dec  = m_rvalid && (m_out > 0);
            if (m_rvalid && m_out == 0) m_err = 1'b1;
            m_out = m_out + int'(inc) - int'(dec);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.add = s_add; e.wen = s_wen; e.be = s_be; e.data = s_data;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sreq, input bit wen, input bit mgnt,
                         input bit rv, input bit c, input bit r);
        s_req    = sreq;
        s_wen    = wen;
        s_add    = $urandom;
        s_data   = {$urandom, $urandom};
        s_be     = 8'($urandom);
        s_lrdy   = 1'($urandom);
        m_gnt    = mgnt;
        m_rvalid = rv;
        m_rdata  = {$urandom, $urandom};
        m_ropc   = 1'($urandom);
        clr      = c;
        rst      = r;
        step();
    endtask

    initial begin
        bit sreq, mgnt, rv, c, r;
        rst = 1'b1; clr = 1'b0; s_req = 1'b0; s_wen = 1'b0; s_add = '0; s_be = '0;
        s_data = '0; s_lrdy = 1'b0; m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_ropc = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 64'(empty), 64'(1));
        check("rst_full",  64'(full),  64'(0));
        check("rst_outst", 64'(outst), 64'(0));
        check("rst_gnt",   64'(s_gnt), 64'(0));

        // Fill: five requests against a stalled downstream, then drain in order
        drive(0, 0, 0, 0, 0, 1);
        repeat (4) drive(1, 0, 0, 0, 0, 0);
        check("fill_full", 64'(full), 64'(1));
        drive(1, 0, 0, 0, 0, 0);
        check("fill_5th_gnt", 64'(s_gnt), 64'(0));
        repeat (4) drive(0, 0, 1, 0, 0, 0);
        check("fill_drained", 64'(empty), 64'(1));

        // Throughput: push and pop every cycle
        drive(0, 0, 0, 0, 0, 1);
        repeat (10) drive(1, 0, 1, 0, 0, 0);
        check("thru_one_entry", 64'(empty), 64'(0));
        drive(0, 0, 1, 0, 0, 0);

        // Outstanding limit with three queued reads
        drive(0, 0, 0, 0, 0, 1);
        repeat (3) drive(1, 1, 0, 0, 0, 0);
        repeat (3) drive(0, 0, 1, 0, 0, 0);
        check("lim_outst", 64'(outst), 64'(2));
        check("lim_blocked", 64'(m_req), 64'(0));
        drive(0, 0, 1, 1, 0, 0);
        check("lim_release", 64'(m_req), 64'(1));
        drive(0, 0, 1, 0, 0, 0);
        check("lim_outst2", 64'(outst), 64'(2));

        // Write past the limit
        drive(1, 0, 0, 0, 0, 0);
        check("wr_req", 64'(m_req), 64'(1));
        drive(0, 0, 1, 0, 0, 0);
        check("wr_outst", 64'(outst), 64'(2));
        check("wr_empty", 64'(empty), 64'(1));

        // Spurious response
        drive(0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0, 0);
        check("spur_err", 64'(rerr), 64'(1));
        check("spur_outst", 64'(outst), 64'(0));
        repeat (3) drive(0, 0, 0, 0, 0, 0);
        check("spur_sticky", 64'(rerr), 64'(1));
        drive(0, 0, 0, 0, 1, 0);
        check("spur_clr", 64'(rerr), 64'(0));

        // Clear mid-operation
        drive(0, 0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0, 0);
        repeat (3) drive(1, 0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0, 0);
        check("clr_pre_outst", 64'(outst), 64'(1));
        drive(0, 0, 0, 0, 1, 0);
        check("clr_empty", 64'(empty), 64'(1));
        check("clr_outst", 64'(outst), 64'(0));
        drive(0, 0, 0, 1, 0, 0);
        check("clr_late_rsp", 64'(rerr), 64'(1));

        // Randomized traffic
        drive(0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 2000; i++) begin
            sreq = ($urandom_range(0, 9) < 6);
            mgnt = ($urandom_range(0, 9) < 6);
            rv   = (m_out > 0) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 99) == 0);
            c    = ($urandom_range(0, 199) == 0);
            r    = ($urandom_range(0, 299) == 0);
            drive(sreq, 1'($urandom), mgnt, rv, c, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/hci_core_req_fifo.md
HCI_CORE_REQ_FIFO -- requirements
Module: hci_core_req_fifo

Interface
REQ-001: Parameter DW, default 64, data width of both HCI ports in bits.
REQ-002: Parameter AW, default 32, address width in bits.
REQ-003: Parameter DEPTH, default 4, number of request entries; SHALL be a power of two, at least 2.
REQ-004: Parameter MAX_OUTSTANDING, default 4, maximum number of in-flight reads; SHALL be at least 1.
REQ-005: clk_i  input  1  single clock; all state updates on rising edge.
REQ-006: rst_i  input  1  synchronous, active-high reset.
REQ-007: clear_i  input  1  synchronous soft clear, active-high.
REQ-008: tcdm_slave  hci_core_intf.slave  DW  upstream requester port; feeds this block.
REQ-009: tcdm_master  hci_core_intf.master  DW  downstream port; drives the wide slave port of the split stage.
REQ-010: empty_o  output  1  FIFO holds 0 entries.
REQ-011: full_o  output  1  FIFO holds DEPTH entries.
REQ-012: outstanding_o  output  $clog2(MAX_OUTSTANDING+1)  current in-flight read count.
REQ-013: resp_err_o  output  1  sticky flag: a response arrived with no outstanding read.

Function
REQ-014: Each entry SHALL store {add, wen, be, data}, width AW+1+DW/8+DW.
REQ-015: Push SHALL occur on tcdm_slave.req & tcdm_slave.gnt.
REQ-016: tcdm_slave.gnt SHALL equal ~full_o & ~rst_i & ~clear_i (combinational).
REQ-017: Pop SHALL occur on tcdm_master.req & tcdm_master.gnt.
REQ-018: tcdm_master.req SHALL equal ~empty_o & (head.wen==0 | outstanding_o < MAX_OUTSTANDING).
REQ-019: tcdm_master add/wen/be/data SHALL be driven from the head entry; the values SHALL be held stable while req=1 and gnt=0.
REQ-020: Minimum latency from push to tcdm_master.req SHALL be 1 cycle; no bypass path exists.
REQ-021: Push and pop in the same cycle SHALL leave the count unchanged. Push SHALL be impossible when full, even if a pop occurs in that cycle.
REQ-022: Read and write pointers SHALL wrap from DEPTH-1 to 0. The count SHALL range from 0 to DEPTH.
REQ-023: A pop with wen=1 (a read) SHALL increment outstanding_o, and tcdm_master.r_valid SHALL decrement it. Both in the same cycle SHALL leave it unchanged.
REQ-024: A write (wen=0) SHALL never be blocked by the outstanding limit and SHALL not change outstanding_o.
REQ-025: r_valid while outstanding_o==0 SHALL set resp_err_o. outstanding_o SHALL stay 0 in that case (no underflow).
REQ-026: tcdm_slave.r_data, r_valid and r_opc SHALL equal the corresponding tcdm_master fields combinationally, with zero latency.
REQ-027: tcdm_master.lrdy SHALL equal tcdm_slave.lrdy.
REQ-028: tcdm_master.user, tcdm_master.boffs and tcdm_slave.r_user SHALL be driven to 0.
REQ-029: Requests SHALL leave in strict FIFO order with no reordering.

Reset
REQ-030: rst_i SHALL have priority over clear_i.
REQ-031: rst_i or clear_i SHALL zero pointers, count, outstanding_o and resp_err_o at the next edge.
REQ-032: While rst_i or clear_i is asserted, tcdm_master.req=0 and tcdm_slave.gnt=0.
REQ-033: After reset: empty_o=1, full_o=0.
REQ-034: Entries pending at reset or clear SHALL be discarded.
REQ-035: Responses arriving after a reset or clear SHALL still be forwarded upstream and SHALL set resp_err_o.

Verification
REQ-036: Fill: DEPTH=4, master gnt=0, upstream issues 5 requests -> 4 granted; full_o=1; 5th held with gnt=0; after gnt=1, all 4 popped in order with addresses intact.
REQ-037: Throughput: master gnt=1 constantly, upstream req every cycle -> one push and one pop per cycle; count stays at 1; no bubbles after the first cycle.
REQ-038: Outstanding limit: MAX_OUTSTANDING=2, three reads queued, no r_valid -> two popped and the third blocked (req=0), outstanding_o=2. One r_valid -> third issues the next cycle.
REQ-039: Write past limit: outstanding_o=2 at max, head is a write -> write issues; outstanding_o stays 2.
REQ-040: Spurious response: r_valid with outstanding_o=0 -> resp_err_o=1 and stays 1 until rst_i or clear_i; outstanding_o stays 0.
REQ-041: Clear mid-operation: 3 entries queued and 1 read outstanding, clear_i pulsed for 1 cycle -> empty_o=1, outstanding_o=0. A later r_valid is forwarded upstream and sets resp_err_o.
